// File: rtl/relu_backward_stream.sv
// Streaming ReLU backward: forward pass records a sign mask, backward pass gates gradients.
// Optional RELU_BWD_LEAKY_EN scales masked gradients by 2^-SLOPE_SHIFT instead of zeroing.
module relu_backward_stream #(
  parameter int DEPTH       = 256,
  parameter int LEN_W       = 9,
  parameter int SLOPE_SHIFT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err_len,
  input  logic             fwd_valid,
  output logic             fwd_ready,
  input  logic [31:0]      fwd_data,
  input  logic             grad_valid,
  output logic             grad_ready,
  input  logic [31:0]      grad_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    BWD,
    DRAIN
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             mask [DEPTH];

  logic        fwd_fire;
  logic        grad_fire;
  logic        out_fire;
  logic        last;
  logic        mask_in;
  logic        mask_rd;
  logic [31:0] gated;

  if (SLOPE_SHIFT < 0 || SLOPE_SHIFT > 254) begin : g_slope_range
    $error("SLOPE_SHIFT out of range");
  end

  assign busy       = state != IDLE;
  assign fwd_ready  = state == FWD;
  assign grad_ready = (state == BWD) && (!out_valid || out_ready);

  assign fwd_fire  = fwd_valid && fwd_ready;
  assign grad_fire = grad_valid && grad_ready;
  assign out_fire  = out_valid && out_ready;
  assign last      = cnt == len_q - 1'b1;

  // Signed zeros count as non-positive; NaN/Inf go by sign alone
  assign mask_in = !fwd_data[31] && (|fwd_data[30:0]);
  assign mask_rd = mask[cnt[AW-1:0]];

`ifdef RELU_BWD_LEAKY_EN
  function automatic logic [31:0] leak(input logic [31:0] g);
    logic [7:0] e;
    e = g[30:23];
    if (e == 8'hff)
      leak = g;
    else if (e <= 8'(SLOPE_SHIFT))
      leak = {g[31], 31'b0};
    else
      leak = {g[31], e - 8'(SLOPE_SHIFT), g[22:0]};
  endfunction

  assign gated = mask_rd ? grad_data : leak(grad_data);
`else
  assign gated = mask_rd ? grad_data : 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (fwd_fire)
      mask[cnt[AW-1:0]] <= mask_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      done      <= 1'b0;
      err_len   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
    end else begin
      done    <= 1'b0;
      err_len <= 1'b0;

      if (grad_fire) begin
        out_valid <= 1'b1;
        out_data  <= gated;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0 || len > LEN_W'(DEPTH)) begin
              err_len <= 1'b1;
            end else begin
              len_q <= len;
              cnt   <= '0;
              state <= FWD;
            end
          end
        end
        FWD: begin
          if (fwd_fire) begin
            if (last) begin
              cnt   <= '0;
              state <= BWD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        BWD: begin
          if (grad_fire) begin
            if (last) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_backward_stream.sv
// Randomized bench for relu_backward_stream against a spec-level queue model.
module tb_relu_backward_stream;

  localparam int DEPTH = 256;
  localparam int LEN_W = 9;
  localparam int SH    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             err_len;
  logic             fwd_valid;
  logic             fwd_ready;
  logic [31:0]      fwd_data;
  logic             grad_valid;
  logic             grad_ready;
  logic [31:0]      grad_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;

  relu_backward_stream #(
    .DEPTH(DEPTH),
    .LEN_W(LEN_W),
    .SLOPE_SHIFT(SH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .len(len),
    .busy(busy),
    .done(done),
    .err_len(err_len),
    .fwd_valid(fwd_valid),
    .fwd_ready(fwd_ready),
    .fwd_data(fwd_data),
    .grad_valid(grad_valid),
    .grad_ready(grad_ready),
    .grad_data(grad_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nbad = 0;

  logic [31:0] fq[$];
  logic [31:0] gq[$];
  logic [31:0] got[$];
  int          gh[$];
  int          oh[$];
  int          dones = 0;
  int          stall_bad = 0;
  bit          hold_prev = 0;
  logic [31:0] hold_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 0;
    end else begin
      if (grad_valid && grad_ready) gh.push_back(cyc);
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        oh.push_back(cyc);
      end
      if (done) dones++;
      if (out_valid && !out_ready && grad_ready) stall_bad++;
      if (hold_prev && (!out_valid || out_data !== hold_data)) stall_bad++;
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  // Spec-level expectation: positive non-zero forward value passes the gradient
  function automatic logic [31:0] model(input logic [31:0] f, input logic [31:0] g);
    bit pos;
    int e;
    pos = (f[31] == 1'b0) && (f[30:0] != 31'd0);
    if (pos) return g;
    e = int'(g[30:23]);
`ifdef RELU_BWD_LEAKY_EN
    if (e == 255) return g;
    if (e <= SH) return {g[31], 31'b0};
    return $shortrealtobits($bitstoshortreal(g) / real'(1 << SH));
`else
    if (e < 0) return g;
    return 32'h0;
`endif
  endfunction

  function automatic void clear_sb();
    got.delete();
    gh.delete();
    oh.delete();
    dones = 0;
    stall_bad = 0;
  endfunction

  function automatic logic [31:0] rand_fwd();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7f80_0000;
      3: return 32'hff80_0000;
      4: return 32'h7fc0_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic start_pass(input int n);
    start = 1'b1;
    len   = n[LEN_W-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // mode 0: full rate, 1: five-cycle output stall, 2: random valids/ready
  task automatic run_pass(input int n, input int mode, input int stop_at, output bit to);
    int fi = 0;
    int gi = 0;
    int stall = 0;
    int c = 0;
    int d0 = dones;
    to = 0;
    forever begin
      fwd_valid  = (fi < n) && (mode != 2 || $urandom_range(3) != 0);
      fwd_data   = (fi < n) ? fq[fi] : $urandom;
      grad_valid = (gi < n) && (mode != 2 || $urandom_range(3) != 0);
      grad_data  = (gi < n) ? gq[gi] : $urandom;
      if (mode == 1) begin
        out_ready = !(got.size() >= 1 && stall < 5);
        if (!out_ready) stall++;
      end else if (mode == 2) begin
        out_ready = 1'($urandom_range(1));
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (fwd_valid && fwd_ready) fi++;
      if (grad_valid && grad_ready) gi++;
      @(posedge clk);
      #1;
      c++;
      if (dones != d0) break;
      if (stop_at > 0 && got.size() >= stop_at) break;
      if (c > 8 * n + 60) begin
        to = 1;
        break;
      end
    end
    fwd_valid  = 1'b0;
    grad_valid = 1'b0;
    out_ready  = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if ({busy, done, err_len, fwd_ready, grad_ready, out_valid, out_data} !== '0) begin
      nbad++;
      $display("FAIL reset_state: got %b/%h required all zero",
               {busy, done, err_len, fwd_ready, grad_ready, out_valid}, out_data);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit to;
    clear_sb();
    fq = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h40000000};
    gq = '{32'h41200000, 32'h41200000, 32'h41200000, 32'h41200000};
    start_pass(4);
    run_pass(4, 0, 0, to);
    nchk++;
    if (to !== 1'b0 || got.size() != 4) begin
      nbad++;
      $display("FAIL basic_count: got %0d outputs timeout=%0d required 4", got.size(), to);
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      nchk++;
      if (got[i] !== model(fq[i], gq[i])) begin
        nbad++;
        $display("FAIL basic_data[%0d]: got %h required %h", i, got[i], model(fq[i], gq[i]));
      end
      nchk++;
      if (oh[i] - gh[i] != 1) begin
        nbad++;
        $display("FAIL basic_latency[%0d]: got %0d required 1", i, oh[i] - gh[i]);
      end
    end
    nchk++;
    if (dones != 1 || busy !== 1'b0) begin
      nbad++;
      $display("FAIL basic_done: got dones=%0d busy=%b required 1/0", dones, busy);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_sb();
    fq.delete();
    gq.delete();
    for (int i = 0; i < 3; i++) begin
      fq.push_back(rand_fwd());
      gq.push_back($urandom);
    end
    start_pass(3);
    run_pass(3, 1, 0, to);
    nchk++;
    if (to !== 1'b0 || got.size() != 3) begin
      nbad++;
      $display("FAIL bp_count: got %0d outputs timeout=%0d required 3", got.size(), to);
    end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      nchk++;
      if (got[i] !== model(fq[i], gq[i])) begin
        nbad++;
        $display("FAIL bp_data[%0d]: got %h required %h", i, got[i], model(fq[i], gq[i]));
      end
    end
    nchk++;
    if (stall_bad != 0) begin
      nbad++;
      $display("FAIL bp_stall: got %0d stall violations required 0", stall_bad);
    end
  endtask

  task automatic test_len_err();
    int bad_lens[2] = '{0, DEPTH + 1};
    foreach (bad_lens[k]) begin
      start_pass(bad_lens[k]);
      nchk++;
      if (err_len !== 1'b1 || busy !== 1'b0) begin
        nbad++;
        $display("FAIL len_err_%0d: got err=%b busy=%b required 1/0", bad_lens[k], err_len, busy);
      end
      @(posedge clk);
      #1;
      nchk++;
      if (err_len !== 1'b0 || busy !== 1'b0) begin
        nbad++;
        $display("FAIL len_err_pulse_%0d: got err=%b busy=%b required 0/0",
                 bad_lens[k], err_len, busy);
      end
    end
  endtask

  task automatic test_full();
    bit to;
    int nerr = 0;
    clear_sb();
    fq.delete();
    gq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      fq.push_back({1'b0, 31'($urandom_range(32'h7fffffff, 1))});
      gq.push_back($urandom);
    end
    start_pass(DEPTH);
    run_pass(DEPTH, 0, 0, to);
    nchk++;
    if (to !== 1'b0 || got.size() != DEPTH) begin
      nbad++;
      $display("FAIL full_count: got %0d outputs timeout=%0d required %0d", got.size(), to, DEPTH);
    end
    for (int i = 0; i < got.size() && i < DEPTH; i++)
      if (got[i] !== gq[i]) nerr++;
    nchk++;
    if (nerr != 0) begin
      nbad++;
      $display("FAIL full_data: got %0d wrong elements required 0", nerr);
    end
  endtask

  task automatic test_random();
    bit to;
    int n;
    for (int r = 0; r < 4; r++) begin
      clear_sb();
      fq.delete();
      gq.delete();
      n = (r == 0) ? 1 : $urandom_range(24, 2);
      for (int i = 0; i < n; i++) begin
        fq.push_back(rand_fwd());
        gq.push_back($urandom);
      end
      start_pass(n);
      run_pass(n, 2, 0, to);
      nchk++;
      if (to !== 1'b0 || got.size() != n || dones != 1) begin
        nbad++;
        $display("FAIL rand%0d_count: got %0d outputs dones=%0d timeout=%0d required %0d/1",
                 r, got.size(), dones, to, n);
      end
      for (int i = 0; i < got.size() && i < n; i++) begin
        nchk++;
        if (got[i] !== model(fq[i], gq[i])) begin
          nbad++;
          $display("FAIL rand%0d_data[%0d]: got %h required %h",
                   r, i, got[i], model(fq[i], gq[i]));
        end
      end
      nchk++;
      if (stall_bad != 0) begin
        nbad++;
        $display("FAIL rand%0d_stall: got %0d violations required 0", r, stall_bad);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int d0;
    clear_sb();
    fq.delete();
    gq.delete();
    for (int i = 0; i < 4; i++) begin
      fq.push_back(rand_fwd());
      gq.push_back($urandom);
    end
    start_pass(4);
    run_pass(4, 0, 2, to);
    nchk++;
    if (to !== 1'b0) begin
      nbad++;
      $display("FAIL rstmid_reach: got timeout=%0d required 0", to);
    end
    d0 = dones;
    #2 reset = 1'b1;
    #1;
    nchk++;
    if ({busy, done, err_len, fwd_ready, grad_ready, out_valid, out_data} !== '0) begin
      nbad++;
      $display("FAIL rstmid_async: got %b/%h required all zero",
               {busy, done, err_len, fwd_ready, grad_ready, out_valid}, out_data);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (dones != d0 || busy !== 1'b0) begin
      nbad++;
      $display("FAIL rstmid_nodone: got dones=%0d busy=%b required %0d/0", dones, busy, d0);
    end
    clear_sb();
    fq = '{32'h3F800000, 32'hC0000000};
    gq.delete();
    gq.push_back($urandom);
    gq.push_back($urandom);
    start_pass(2);
    run_pass(2, 0, 0, to);
    nchk++;
    if (to !== 1'b0 || got.size() != 2 || dones != 1) begin
      nbad++;
      $display("FAIL rstmid_next: got %0d outputs dones=%0d required 2/1", got.size(), dones);
    end else begin
      nchk++;
      if (got[0] !== model(fq[0], gq[0]) || got[1] !== model(fq[1], gq[1])) begin
        nbad++;
        $display("FAIL rstmid_data: got %h %h required %h %h", got[0], got[1],
                 model(fq[0], gq[0]), model(fq[1], gq[1]));
      end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    clear_sb();
    fq.delete();
    gq.delete();
    for (int i = 0; i < 3; i++) begin
      fq.push_back(32'h3F800000);
      gq.push_back($urandom);
    end
    start_pass(3);
    start = 1'b1;
    len   = LEN_W'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    nchk++;
    if (fwd_ready !== 1'b1 || err_len !== 1'b0) begin
      nbad++;
      $display("FAIL ignstart_state: got fwd_ready=%b err=%b required 1/0", fwd_ready, err_len);
    end
    run_pass(3, 0, 0, to);
    nchk++;
    if (to !== 1'b0 || got.size() != 3 || dones != 1) begin
      nbad++;
      $display("FAIL ignstart_len: got %0d outputs dones=%0d timeout=%0d required 3/1",
               got.size(), dones, to);
    end
  endtask

`ifdef RELU_BWD_LEAKY_EN
  task automatic test_leaky();
    bit to;
    logic [31:0] req[3] = '{32'h3FA00000, 32'h00000000, 32'hBFA00000};
    clear_sb();
    fq = '{32'hBF800000, 32'hBF800000, 32'hBF800000};
    gq = '{32'h41200000, 32'h00800000, 32'hC1200000};
    start_pass(3);
    run_pass(3, 0, 0, to);
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (i >= got.size() || got[i] !== req[i]) begin
        nbad++;
        $display("FAIL leaky[%0d]: got %h required %h", i,
                 (i < got.size()) ? got[i] : 32'hxxxxxxxx, req[i]);
      end
    end
  endtask
`endif

  initial begin
    start      = 1'b0;
    len        = '0;
    fwd_valid  = 1'b0;
    fwd_data   = '0;
    grad_valid = 1'b0;
    grad_data  = '0;
    out_ready  = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_len_err();
    test_full();
    test_random();
    test_reset_mid();
    test_start_ignored();
`ifdef RELU_BWD_LEAKY_EN
    test_leaky();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/relu_backward_stream.md
Name: relu_backward_stream

Overview:
- Streaming ReLU backward stage for one layer pass, operating on one element per cycle.
- Forward pass: captures a 1-bit activation mask per element from the forward-pass input stream.
- Backward pass: gates the incoming top-gradient stream with that mask and emits the bottom gradient.
- Position in design: sits directly downstream of the ReLU forward/backward element datapath. Feeds the layer's gradient writeback path through a valid/ready interface.

Parameters:
- DEPTH, 256, maximum elements per pass (mask storage size).
- LEN_W, 9, width of the len input; must satisfy 2^LEN_W > DEPTH.
- SLOPE_SHIFT, 3, leaky slope exponent 2^-SLOPE_SHIFT; used only with the optional feature.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, begins a pass; sampled only in IDLE.
- len, input, LEN_W, element count for the pass; latched on start.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse when the pass completes.
- err_len, output, 1, one-cycle pulse when start is rejected.
- fwd_valid, input, 1, forward-data valid.
- fwd_ready, output, 1, forward-data ready.
- fwd_data, input, 32, forward input (IEEE-754 single).
- grad_valid, input, 1, top-gradient valid.
- grad_ready, output, 1, top-gradient ready.
- grad_data, input, 32, top gradient (float).
- out_valid, output, 1, bottom-gradient valid.
- out_ready, input, 1, downstream ready.
- out_data, output, 32, bottom gradient (float).

Behaviour:
- Reset (async, active-high):
  - state=IDLE, cnt=0, len_q=0.
  - busy, done, err_len, fwd_ready, grad_ready, out_valid all 0; out_data=32'h0.
  - Mask storage is not reset.
- Reset mid-pass: aborts immediately, no done pulse; the next pass starts cleanly.
- State machine: IDLE -> FWD -> BWD -> DRAIN -> IDLE.
- IDLE:
  - start with 1 <= len <= DEPTH: latch len_q, cnt=0, go to FWD.
  - start with len == 0 or len > DEPTH: err_len pulses 1 cycle; stay IDLE.
  - start outside IDLE is ignored.
- FWD:
  - fwd_ready=1 combinationally in FWD only.
  - Each fwd handshake writes mask[cnt] and increments cnt.
  - mask = 1 iff fwd_data[31]==0 and fwd_data[30:0]!=0. Both +0 and -0 give mask 0; NaN/Inf are classified by sign bit only.
  - Handshake with cnt==len_q-1: cnt=0, go to BWD.
- BWD:
  - grad_ready = !out_valid || out_ready (single output register; full throughput, no bubbles).
  - On grad handshake, out_data is registered as grad_data if mask[cnt]==1, else 32'h0000_0000. out_valid is set, and cnt increments.
  - Latency: 1 cycle from grad handshake to out_valid.
  - Handshake with cnt==len_q-1: go to DRAIN.
- Output register:
  - out_valid holds and out_data is stable until out_ready.
  - On the same cycle as an out handshake, a new grad handshake may reload the register (out_valid stays 1).
- DRAIN:
  - grad_ready=0.
  - When out_valid==0, or on the out handshake of the last element: done pulses 1 cycle (the cycle after), then go to IDLE.
- len_q==1 is legal: FWD and BWD each last one handshake.
- fwd_data/grad_data are ignored outside their respective states; ready is 0 there.

Optional Feature:
- Macro: RELU_BWD_LEAKY_EN.
- Defined (leaky ReLU backward): masked elements output grad_data * 2^-SLOPE_SHIFT.
  - Implemented as exponent decrement: sign and mantissa kept.
  - If the exponent is <= SLOPE_SHIFT, or grad is zero/denormal, the output is signed zero {sign, 31'b0}.
  - Inf/NaN pass through unchanged.
- Undefined: masked elements output 32'h0 as above; no exponent logic is synthesized.

Test Plan:
- Basic pass:
  - Stimulus: len=4; fwd = {3F800000, BF800000, 00000000, 40000000}; grad = {41200000 x4}, out_ready=1.
  - Required: out = {41200000, 00000000, 00000000, 41200000}, each 1 cycle after its grad handshake; done pulses once; busy drops.
- Back-pressure:
  - Stimulus: len=3, out_ready low for 5 cycles mid-stream.
  - Required: grad_ready=0 while out_valid && !out_ready; out_data stable during the stall; no element lost or duplicated.
- Length errors:
  - start with len=0 -> err_len pulse, busy stays 0.
  - start with len=257 (DEPTH=256) -> err_len pulse, busy stays 0.
  - start with len=256, all fwd positive -> 256 outputs equal to the grads.
- Reset mid-pass:
  - Stimulus: assert reset during BWD after 2 of 4 outputs.
  - Required: all outputs 0 asynchronously, no done pulse; a new len=2 pass then completes correctly.
- Leaky (RELU_BWD_LEAKY_EN, SLOPE_SHIFT=3):
  - fwd=BF800000, grad=41200000 -> out=3FA00000.
  - grad=00800000 -> out=00000000.
  - grad=C1200000 -> out=BFA00000.
- Start ignored while busy: a start pulse during FWD changes neither len_q nor state; the pass completes with the original len.
